mul_rr_scheduler: RTL

- Shares one `multiplier_msu` instance among NREQ requesters.
- Each requester presents an operand pair plus a signedness mode over a valid/ready handshake.
- The scheduler grants requesters round-robin, registers operands in front of the combinational array and registers the product behind it.
- Results return tagged with the requester index. Sits between the datapath issue logic and the shared multiplier resource.

---
 rtl/mul_sched_pkg.sv | 22 ++
 rtl/multiplier_msu.sv | 17 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/mul_rr_scheduler.sv | 97 +++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: mode enum, mode-to-pin decode and the pipeline stage control structs.
package mul_sched_pkg;
   typedef enum logic [1:0] {
      MODE_U    = 2'b00,
      MODE_S    = 2'b01,
      MODE_MIX  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;
   typedef struct packed {
      logic valid;
      logic sign;
      logic mix;
      logic err;
   } s1_ctl_t;
   typedef struct packed {
      logic valid;
      logic err;
   } s2_ctl_t;
   function automatic logic [1:0] mode_pins(mode_e m);
      return {m == MODE_S, m == MODE_MIX};
   endfunction
endpackage

// File: rtl/multiplier_msu.sv
// multiplier_msu: combinational SIZExSIZE multiply, a/b unsigned, both signed (sign) or a signed b unsigned (mix).
module multiplier_msu #(
   parameter int SIZE = 32
) (
   input  logic [SIZE-1:0]   a,
   input  logic [SIZE-1:0]   b,
   input  logic              sign,
   input  logic              mix,
   output logic [2*SIZE-1:0] y
);
   logic [2*SIZE-1:0] ea, eb;
   always_comb begin
      ea = {{SIZE{(sign | mix) & a[SIZE-1]}}, a};
      eb = {{SIZE{sign & b[SIZE-1]}}, b};
      y  = ea * eb;
   end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first req at or after ptr; one-hot gnt plus encoded idx.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);
   logic [IW-1:0] c;
   always_comb begin
      gnt = '0;
      idx = '0;
      c   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         c = IW'((int'(ptr) + k) % N);
         if (en && req[c]) begin
            gnt    = '0;
            gnt[c] = 1'b1;
            idx    = c;
         end
      end
   end
endmodule

// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler: round-robin shares one multiplier_msu among NREQ valid/ready requesters; S1 operands -> multiplier -> S2 tagged result (rsp_*), busy while either stage is full.
module mul_rr_scheduler
   import mul_sched_pkg::*;
#(
   parameter int SIZE = 32,
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*SIZE-1:0] req_a,
   input  logic [NREQ*SIZE-1:0] req_b,
   input  logic [2*NREQ-1:0]    req_mode,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [2*SIZE-1:0]    rsp_y,
   output logic                 rsp_err,
   output logic                 busy
);
   s1_ctl_t           s1_q, s1_d;
   s2_ctl_t           s2_q, s2_d;
   logic [SIZE-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
   logic [IDW-1:0]    s1_id_q, s1_id_d, s2_id_q, s2_id_d, ptr_q, ptr_d, gidx;
   logic [2*SIZE-1:0] s2_y_q, s2_y_d, mul_y;
   logic [NREQ-1:0]   gnt;
   logic              adv1, adv2, xfer;
   logic [1:0]        gpins;
   mode_e             gmode;
   logic [SIZE-1:0]   a_arr [NREQ];
   logic [SIZE-1:0]   b_arr [NREQ];
   mode_e             m_arr [NREQ];
   for (genvar r = 0; r < NREQ; r++) begin : g_unpack
      assign a_arr[r] = req_a[r*SIZE +: SIZE];
      assign b_arr[r] = req_b[r*SIZE +: SIZE];
      assign m_arr[r] = mode_e'(req_mode[2*r +: 2]);
   end
   assign adv2      = ~s2_q.valid | rsp_ready;
   assign adv1      = ~s1_q.valid | adv2;
   assign xfer      = |gnt;
   assign req_ready = gnt;
   rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .en  (adv1 & ~rst),
      .gnt (gnt),
      .idx (gidx)
   );
   multiplier_msu #(.SIZE(SIZE)) u_mul (
      .a    (s1_a_q),
      .b    (s1_b_q),
      .sign (s1_q.sign),
      .mix  (s1_q.mix),
      .y    (mul_y)
   );
   always_comb begin
      gmode   = m_arr[gidx];
      gpins   = mode_pins(gmode);
      s1_d    = xfer ? s1_ctl_t'{valid: 1'b1, sign: gpins[1], mix: gpins[0], err: gmode == MODE_RSVD}
                     : s1_ctl_t'{valid: s1_q.valid & ~adv1, sign: s1_q.sign, mix: s1_q.mix, err: s1_q.err};
      s1_a_d  = xfer ? a_arr[gidx] : s1_a_q;
      s1_b_d  = xfer ? b_arr[gidx] : s1_b_q;
      s1_id_d = xfer ? gidx : s1_id_q;
      s2_d    = adv2 ? s2_ctl_t'{valid: s1_q.valid, err: s1_q.valid ? s1_q.err : s2_q.err} : s2_q;
      s2_y_d  = adv2 && s1_q.valid ? (s1_q.err ? '0 : mul_y) : s2_y_q;
      s2_id_d = adv2 && s1_q.valid ? s1_id_q : s2_id_q;
      ptr_d   = xfer ? (gidx == IDW'(NREQ - 1) ? '0 : gidx + 1'b1) : ptr_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= '0;
         s2_q    <= '0;
         s1_a_q  <= '0;
         s1_b_q  <= '0;
         s1_id_q <= '0;
         s2_id_q <= '0;
         s2_y_q  <= '0;
         ptr_q   <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         s1_a_q  <= s1_a_d;
         s1_b_q  <= s1_b_d;
         s1_id_q <= s1_id_d;
         s2_id_q <= s2_id_d;
         s2_y_q  <= s2_y_d;
         ptr_q   <= ptr_d;
      end
   end
   assign rsp_valid = s2_q.valid;
   assign rsp_err   = s2_q.err;
   assign rsp_id    = s2_id_q;
   assign rsp_y     = s2_y_q;
   assign busy      = s1_q.valid | s2_q.valid;
endmodule
